// File: rtl/commit_unit.sv
// ---------------------------------------------------------------------------
// commit_unit
//
// Retirement stage that sits directly after the reorder buffer. It accepts
// at most one in-order commit per cycle and carries out that commit's
// architectural side effects:
//   - register-file write, registered, one cycle after accept;
//   - store enqueue into a small FIFO store queue that drains to data memory;
//   - taken-branch redirect: a one-cycle flush/redirect pulse, after which
//     commit stays blocked for FLUSH_CYCLES cycles.
//
// Optional feature (macro COMMIT_PERF_CNT_EN):
//   When defined, the block adds the instret_o[63:0] and
//   branch_redirect_cnt_o[31:0] performance counters. Both reset to 0 and
//   wrap silently. When undefined, the ports and counters do not exist.
//
// Parameters
//   SQ_DEPTH      store-queue entries (power of two, >= 2)
//   FLUSH_CYCLES  cycles commit is blocked after a redirect (>= 1)
//
// Ports
//   clk_i, rst_i                    clock; asynchronous active-high reset
//   commit_valid_i/commit_ready_o   ROB head handshake (pop on valid&&ready)
//   commit_pc_i                     PC of the committing instruction
//   commit_rd_addr_i                destination register
//   commit_result_i                 ALU result, or store address for stores
//   commit_store_data_i             store data
//   commit_write_enable_i           instruction writes rd
//   commit_store_to_mem_i           instruction is a store
//   commit_new_pc_i                 resolved next PC
//   commit_branch_taken_i           taken control transfer, redirect needed
//   rf_we_o/rf_waddr_o/rf_wdata_o   register-file write port
//   flush_o                         one-cycle pipeline/ROB flush pulse
//   redirect_valid_o/redirect_pc_o  fetch redirect (pc holds when not valid)
//   dmem_req_o/dmem_addr_o/
//   dmem_wdata_o/dmem_ack_i         store-queue head write to data memory
//   sq_empty_o                      store queue empty (fence/drain status)
//   instret_o, branch_redirect_cnt_o  (COMMIT_PERF_CNT_EN only)
// ---------------------------------------------------------------------------
module commit_unit #(
    parameter int SQ_DEPTH     = 4,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,

    input  logic        commit_valid_i,
    output logic        commit_ready_o,
    input  logic [31:0] commit_pc_i,
    input  logic [4:0]  commit_rd_addr_i,
    input  logic [31:0] commit_result_i,
    input  logic [31:0] commit_store_data_i,
    input  logic        commit_write_enable_i,
    input  logic        commit_store_to_mem_i,
    input  logic [31:0] commit_new_pc_i,
    input  logic        commit_branch_taken_i,

    output logic        rf_we_o,
    output logic [4:0]  rf_waddr_o,
    output logic [31:0] rf_wdata_o,

    output logic        flush_o,
    output logic        redirect_valid_o,
    output logic [31:0] redirect_pc_o,

    output logic        dmem_req_o,
    output logic [31:0] dmem_addr_o,
    output logic [31:0] dmem_wdata_o,
    input  logic        dmem_ack_i,

`ifdef COMMIT_PERF_CNT_EN
    output logic [63:0] instret_o,
    output logic [31:0] branch_redirect_cnt_o,
`endif
    output logic        sq_empty_o
);

    localparam int PTR_W = (SQ_DEPTH > 1) ? $clog2(SQ_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int FC_W  = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES + 1) : 1;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    state_t            state;
    logic [FC_W-1:0]   flush_cnt;

    logic [PTR_W-1:0]  sq_wr_ptr;
    logic [PTR_W-1:0]  sq_rd_ptr;
    logic [CNT_W-1:0]  sq_count;
    logic [31:0]       sq_addr [SQ_DEPTH];
    logic [31:0]       sq_data [SQ_DEPTH];

    logic acc;
    logic sq_push;
    logic sq_pop;

    // The PC travels with the commit for trace/debug only; no side effect
    // of retirement depends on it.
    logic unused_pc;
    assign unused_pc = ^commit_pc_i;

    // Ready is a function of state and queue occupancy only, so the ROB
    // never sees a combinational path from its own valid back to ready.
    assign commit_ready_o = (state == ST_RUN) && (sq_count != CNT_W'(SQ_DEPTH));
    assign acc            = commit_valid_i && commit_ready_o;

    // The head is presented combinationally; since sq_count is reset
    // asynchronously, dmem_req_o falls the moment rst_i rises.
    assign sq_empty_o   = (sq_count == '0);
    assign dmem_req_o   = !sq_empty_o;
    assign dmem_addr_o  = sq_addr[sq_rd_ptr];
    assign dmem_wdata_o = sq_data[sq_rd_ptr];

    assign sq_push = acc && commit_store_to_mem_i;
    assign sq_pop  = dmem_req_o && dmem_ack_i;

    // ------------------------------------------------------------------
    // Retirement FSM, RF write port and redirect pulse.
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state            <= ST_RUN;
            flush_cnt        <= '0;
            rf_we_o          <= 1'b0;
            rf_waddr_o       <= '0;
            rf_wdata_o       <= '0;
            flush_o          <= 1'b0;
            redirect_valid_o <= 1'b0;
            redirect_pc_o    <= '0;
        end else begin
            // Writes to x0 are architecturally void and never reach the RF.
            rf_we_o <= acc && commit_write_enable_i && (commit_rd_addr_i != 5'd0);
            if (acc && commit_write_enable_i && (commit_rd_addr_i != 5'd0)) begin
                rf_waddr_o <= commit_rd_addr_i;
                rf_wdata_o <= commit_result_i;
            end

            flush_o          <= acc && commit_branch_taken_i;
            redirect_valid_o <= acc && commit_branch_taken_i;
            if (acc && commit_branch_taken_i) begin
                redirect_pc_o <= commit_new_pc_i;
            end

            case (state)
                ST_RUN: begin
                    if (acc && commit_branch_taken_i) begin
                        state     <= ST_FLUSH;
                        flush_cnt <= FC_W'(FLUSH_CYCLES);
                    end
                end
                ST_FLUSH: begin
                    // The counter reaches 0 on the same edge that returns to
                    // RUN, giving exactly FLUSH_CYCLES blocked cycles.
                    flush_cnt <= flush_cnt - 1'b1;
                    if (flush_cnt == FC_W'(1)) begin
                        state <= ST_RUN;
                    end
                end
                default: state <= ST_RUN;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Store-queue control. Stores already queued are architectural and
    // keep draining while the pipeline is flushing.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sq_wr_ptr <= '0;
            sq_rd_ptr <= '0;
            sq_count  <= '0;
        end else begin
            if (sq_push) begin
                sq_wr_ptr <= sq_wr_ptr + 1'b1;
            end
            if (sq_pop) begin
                sq_rd_ptr <= sq_rd_ptr + 1'b1;
            end
            case ({sq_push, sq_pop})
                2'b10:   sq_count <= sq_count + 1'b1;
                2'b01:   sq_count <= sq_count - 1'b1;
                default: sq_count <= sq_count;
            endcase
        end
    end

    // NOTE: the queue storage has no reset; the pointers and count decide
    // which entries are live, so stale contents are never observed.
    always_ff @(posedge clk_i) begin
        if (sq_push) begin
            sq_addr[sq_wr_ptr] <= commit_result_i;
            sq_data[sq_wr_ptr] <= commit_store_data_i;
        end
    end

`ifdef COMMIT_PERF_CNT_EN
    // ------------------------------------------------------------------
    // Performance counters; both wrap silently.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            instret_o             <= '0;
            branch_redirect_cnt_o <= '0;
        end else begin
            if (acc) begin
                instret_o <= instret_o + 64'd1;
            end
            if (acc && commit_branch_taken_i) begin
                branch_redirect_cnt_o <= branch_redirect_cnt_o + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_commit_unit.sv
// ---------------------------------------------------------------------------
// tb_commit_unit
//
// Directed bench for commit_unit with hand-computed expectations. Inputs are
// driven 1 time unit after the rising edge; outputs are sampled at that same
// point, well away from the active edge.
// ---------------------------------------------------------------------------
module tb_commit_unit;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        commit_valid_i;
    logic        commit_ready_o;
    logic [31:0] commit_pc_i;
    logic [4:0]  commit_rd_addr_i;
    logic [31:0] commit_result_i;
    logic [31:0] commit_store_data_i;
    logic        commit_write_enable_i;
    logic        commit_store_to_mem_i;
    logic [31:0] commit_new_pc_i;
    logic        commit_branch_taken_i;
    logic        rf_we_o;
    logic [4:0]  rf_waddr_o;
    logic [31:0] rf_wdata_o;
    logic        flush_o;
    logic        redirect_valid_o;
    logic [31:0] redirect_pc_o;
    logic        dmem_req_o;
    logic [31:0] dmem_addr_o;
    logic [31:0] dmem_wdata_o;
    logic        dmem_ack_i;
    logic        sq_empty_o;
`ifdef COMMIT_PERF_CNT_EN
    logic [63:0] instret_o;
    logic [31:0] branch_redirect_cnt_o;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk_i = ~clk_i;

    commit_unit #(.SQ_DEPTH(4), .FLUSH_CYCLES(2)) dut (
        .clk_i                 (clk_i),
        .rst_i                 (rst_i),
        .commit_valid_i        (commit_valid_i),
        .commit_ready_o        (commit_ready_o),
        .commit_pc_i           (commit_pc_i),
        .commit_rd_addr_i      (commit_rd_addr_i),
        .commit_result_i       (commit_result_i),
        .commit_store_data_i   (commit_store_data_i),
        .commit_write_enable_i (commit_write_enable_i),
        .commit_store_to_mem_i (commit_store_to_mem_i),
        .commit_new_pc_i       (commit_new_pc_i),
        .commit_branch_taken_i (commit_branch_taken_i),
        .rf_we_o               (rf_we_o),
        .rf_waddr_o            (rf_waddr_o),
        .rf_wdata_o            (rf_wdata_o),
        .flush_o               (flush_o),
        .redirect_valid_o      (redirect_valid_o),
        .redirect_pc_o         (redirect_pc_o),
        .dmem_req_o            (dmem_req_o),
        .dmem_addr_o           (dmem_addr_o),
        .dmem_wdata_o          (dmem_wdata_o),
        .dmem_ack_i            (dmem_ack_i),
`ifdef COMMIT_PERF_CNT_EN
        .instret_o             (instret_o),
        .branch_redirect_cnt_o (branch_redirect_cnt_o),
`endif
        .sq_empty_o            (sq_empty_o)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs();
        commit_valid_i        = 1'b0;
        commit_pc_i           = '0;
        commit_rd_addr_i      = '0;
        commit_result_i       = '0;
        commit_store_data_i   = '0;
        commit_write_enable_i = 1'b0;
        commit_store_to_mem_i = 1'b0;
        commit_new_pc_i       = '0;
        commit_branch_taken_i = 1'b0;
        dmem_ack_i            = 1'b0;
    endtask

    // Offer a store (address, data) on the commit port without advancing time.
    task automatic offer_store(input logic [31:0] addr, input logic [31:0] data);
        commit_valid_i        = 1'b1;
        commit_store_to_mem_i = 1'b1;
        commit_write_enable_i = 1'b0;
        commit_branch_taken_i = 1'b0;
        commit_result_i       = addr;
        commit_store_data_i   = data;
    endtask

    initial begin
        idle_inputs();
        rst_i = 1'b1;
        #1;
        // Reset state.
        check("rst_ready",    commit_ready_o,   1);
        check("rst_sq_empty", sq_empty_o,       1);
        check("rst_dmem_req", dmem_req_o,       0);
        check("rst_rf_we",    rf_we_o,          0);
        check("rst_flush",    flush_o,          0);
        check("rst_redir_v",  redirect_valid_o, 0);
        check("rst_redir_pc", redirect_pc_o,    0);
        tick();
        tick();
        rst_i = 1'b0;
        tick();

        // ALU commit writes rd one cycle later, no flush.
        commit_valid_i        = 1'b1;
        commit_pc_i           = 32'h04;
        commit_rd_addr_i      = 5'd1;
        commit_result_i       = 32'hDEADBEEF;
        commit_write_enable_i = 1'b1;
        check("alu_ready", commit_ready_o, 1);
        tick();
        idle_inputs();
        check("alu_rf_we",    rf_we_o,    1);
        check("alu_rf_waddr", rf_waddr_o, 1);
        check("alu_rf_wdata", rf_wdata_o, 32'hDEADBEEF);
        check("alu_no_flush", flush_o,    0);
`ifdef COMMIT_PERF_CNT_EN
        check("alu_instret", instret_o, 1);
`endif
        tick();
        check("alu_rf_we_drop", rf_we_o, 0);

        // Write to x0 is suppressed.
        commit_valid_i        = 1'b1;
        commit_rd_addr_i      = 5'd0;
        commit_result_i       = 32'h12345678;
        commit_write_enable_i = 1'b1;
        tick();
        idle_inputs();
        check("x0_rf_we", rf_we_o, 0);

        // Fill the store queue with memory stalled.
        for (int i = 0; i < 4; i++) begin
            offer_store(32'h100 + 32'(4 * i), 32'hA0 + 32'(i));
            check($sformatf("fill_ready_%0d", i), commit_ready_o, 1);
            tick();
        end
        idle_inputs();
        check("full_ready",    commit_ready_o, 0);
        check("full_req",      dmem_req_o,     1);
        check("full_not_empty", sq_empty_o,    0);
        // Drain one per cycle, strictly in order.
        for (int i = 0; i < 4; i++) begin
            check($sformatf("drain_addr_%0d", i), dmem_addr_o, 32'h100 + 32'(4 * i));
            check($sformatf("drain_data_%0d", i), dmem_wdata_o, 32'hA0 + 32'(i));
            dmem_ack_i = 1'b1;
            tick();
        end
        dmem_ack_i = 1'b0;
        check("drain_empty", sq_empty_o,     1);
        check("drain_req",   dmem_req_o,     0);
        check("drain_ready", commit_ready_o, 1);

        // Taken branch; a younger ALU op is held valid throughout the flush.
        commit_valid_i        = 1'b1;
        commit_branch_taken_i = 1'b1;
        commit_new_pc_i       = 32'h40;
        tick();
        commit_branch_taken_i = 1'b0;
        commit_new_pc_i       = 32'h999;
        commit_rd_addr_i      = 5'd5;
        commit_result_i       = 32'h55;
        commit_write_enable_i = 1'b1;
        check("br_flush",      flush_o,          1);
        check("br_redir_v",    redirect_valid_o, 1);
        check("br_redir_pc",   redirect_pc_o,    32'h40);
        check("br_ready_c1",   commit_ready_o,   0);
        check("br_branch_nowr", rf_we_o,         0);
        tick();
        check("br_flush_drop", flush_o,          0);
        check("br_redir_drop", redirect_valid_o, 0);
        check("br_redir_hold", redirect_pc_o,    32'h40);
        check("br_ready_c2",   commit_ready_o,   0);
        check("br_held_nowr",  rf_we_o,          0);
        tick();
        check("br_ready_back", commit_ready_o,   1);
        check("br_held_nowr2", rf_we_o,          0);
        tick();
        idle_inputs();
        check("br_held_acc_we",   rf_we_o,    1);
        check("br_held_acc_addr", rf_waddr_o, 5);
        check("br_no_reflush",    flush_o,    0);
`ifdef COMMIT_PERF_CNT_EN
        check("br_redirect_cnt", branch_redirect_cnt_o, 1);
`endif

        // Full queue with simultaneous ack and a new store offered.
        for (int i = 0; i < 4; i++) begin
            offer_store(32'h200 + 32'(4 * i), 32'hB0 + 32'(i));
            tick();
        end
        offer_store(32'h210, 32'hB4);
        dmem_ack_i = 1'b1;
        check("fa_ready_full", commit_ready_o, 0);
        tick();
        dmem_ack_i = 1'b0;
        check("fa_head_after_pop", dmem_addr_o,    32'h204);
        check("fa_ready_next",     commit_ready_o, 1);
        tick();
        idle_inputs();
        check("fa_full_again", commit_ready_o, 0);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("fa_order_%0d", i), dmem_addr_o, 32'h204 + 32'(4 * i));
            dmem_ack_i = 1'b1;
            tick();
        end
        dmem_ack_i = 1'b0;
        check("fa_empty", sq_empty_o, 1);

        // Asynchronous reset with two stores queued.
        offer_store(32'h300, 32'hC0);
        tick();
        offer_store(32'h304, 32'hC1);
        tick();
        idle_inputs();
        check("ar_req_before", dmem_req_o, 1);
        #2;
        rst_i = 1'b1;
        #1;
        check("ar_req_drop", dmem_req_o,     0);
        check("ar_empty",    sq_empty_o,     1);
        check("ar_ready",    commit_ready_o, 1);
`ifdef COMMIT_PERF_CNT_EN
        check("ar_instret",      instret_o,             0);
        check("ar_redirect_cnt", branch_redirect_cnt_o, 0);
`endif
        tick();
        rst_i = 1'b0;
        tick();
        check("ar_still_empty", sq_empty_o, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
